// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Input-conditioning stage for raw board push-buttons. Each channel is brought
// into the CLK domain through a 2-flop synchronizer and then debounced: a new
// level is accepted only after the synchronized input has differed from the
// current level for DEBOUNCE_CYCLES consecutive cycles. Accepted edges produce
// registered one-cycle PRESSED / RELEASED pulses, aligned with the level change.
//
// Optional feature (compile-time macro BTN_AUTOREPEAT_EN):
//   Channels selected by REPEAT_MASK emit extra PRESSED pulses while held:
//   the first one REPEAT_DELAY cycles after the initial press pulse, then one
//   every REPEAT_PERIOD cycles until the release is accepted. Without the macro
//   no repeat logic exists and the REPEAT_* parameters have no effect.
//
// Ports:
//   CLK           in   system clock (40 MHz)
//   RESET_N       in   asynchronous active-low reset, clears all state
//   BTN_RAW       in   [NUM_BUTTONS] raw asynchronous active-high button pins
//   BTN_LEVEL     out  [NUM_BUTTONS] debounced level, registered
//   BTN_PRESSED   out  [NUM_BUTTONS] one-cycle pulse on accepted press / repeat
//   BTN_RELEASED  out  [NUM_BUTTONS] one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned            NUM_BUTTONS     = 4,
  parameter int unsigned            DEBOUNCE_CYCLES = 400000,
  parameter int unsigned            REPEAT_DELAY    = 12000000,
  parameter int unsigned            REPEAT_PERIOD   = 4000000,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = 4'b0011
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NUM_BUTTONS-1:0] BTN_RAW,
  output logic [NUM_BUTTONS-1:0] BTN_LEVEL,
  output logic [NUM_BUTTONS-1:0] BTN_PRESSED,
  output logic [NUM_BUTTONS-1:0] BTN_RELEASED
);

  // Counter holds at most DEBOUNCE_CYCLES-1, so this width never wraps.
  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal configurations at elaboration time.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      $bits(REPEAT_MASK) != NUM_BUTTONS) begin : g_bad_params
    $error("button_conditioner: illegal parameter values");
  end

  logic [NUM_BUTTONS-1:0] s1_q, s1_d;
  logic [NUM_BUTTONS-1:0] s2_q, s2_d;
  logic [NUM_BUTTONS-1:0] level_q, level_d;
  logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
  logic [NUM_BUTTONS-1:0] released_q, released_d;
  logic [CNT_W-1:0]       db_cnt_q [NUM_BUTTONS];
  logic [CNT_W-1:0]       db_cnt_d [NUM_BUTTONS];

  // Accepted transitions this cycle (combinational, pre-register).
  logic [NUM_BUTTONS-1:0] accept_rise;
  logic [NUM_BUTTONS-1:0] accept_fall;

  // ---------------------------------------------------------------------------
  // Synchronizer and debounce
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    s1_d        = BTN_RAW;
    s2_d        = s1_q;
    accept_rise = '0;
    accept_fall = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      db_cnt_d[i] = '0;
      // Any cycle where s2 agrees with the level restarts the count, which is
      // what rejects bounces shorter than DEBOUNCE_CYCLES.
      if (s2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          accept_rise[i] = s2_q[i];
          accept_fall[i] = ~s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
    level_d    = level_q ^ (accept_rise | accept_fall);
    released_d = accept_fall;
  end

`ifdef BTN_AUTOREPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat, one FSM + counter per channel (only masked channels move)
  // ---------------------------------------------------------------------------
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                   : REPEAT_PERIOD;
  localparam int unsigned      RPT_W       = $clog2(RPT_MAX) + 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  rpt_state_e             rpt_state_q [NUM_BUTTONS];
  rpt_state_e             rpt_state_d [NUM_BUTTONS];
  logic [RPT_W-1:0]       rpt_cnt_q   [NUM_BUTTONS];
  logic [RPT_W-1:0]       rpt_cnt_d   [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] rpt_fire;

  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      rpt_state_d[i] = RPT_IDLE;
      rpt_cnt_d[i]   = '0;
      if (REPEAT_MASK[i]) begin
        rpt_state_d[i] = rpt_state_q[i];
        rpt_cnt_d[i]   = rpt_cnt_q[i];
        unique case (rpt_state_q[i])
          RPT_IDLE: begin
            if (accept_rise[i]) begin
              rpt_state_d[i] = RPT_DELAY;
              rpt_cnt_d[i]   = '0;
            end
          end
          RPT_DELAY: begin
            if (rpt_cnt_q[i] == DELAY_LAST) begin
              rpt_fire[i]    = 1'b1;
              rpt_cnt_d[i]   = '0;
              rpt_state_d[i] = RPT_REPEAT;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (rpt_cnt_q[i] == PERIOD_LAST) begin
              rpt_fire[i]  = 1'b1;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
          end
          default: begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_cnt_d[i]   = '0;
          end
        endcase
        // An accepted release wins over a repeat due in the same cycle.
        if (accept_fall[i]) begin
          rpt_fire[i]    = 1'b0;
          rpt_state_d[i] = RPT_IDLE;
          rpt_cnt_d[i]   = '0;
        end
      end
    end
    pressed_d = accept_rise | rpt_fire;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        rpt_state_q[i] <= RPT_IDLE;
        rpt_cnt_q[i]   <= '0;
      end
    end else begin
      rpt_state_q <= rpt_state_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end
`else
  always_comb begin
    pressed_d = accept_rise;
  end
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q       <= '0;
      s2_q       <= '0;
      level_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      // NOTE: the counter array is plain flops rather than a RAM, so it is reset like any register.
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values together.
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign BTN_LEVEL    = level_q;
  assign BTN_PRESSED  = pressed_q;
  assign BTN_RELEASED = released_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20,
// REPEAT_PERIOD=5, REPEAT_MASK=4'b0011). Directed scenarios plus randomized
// bouncy stimulus are compared every cycle against a reference model that
// accepts a level when the last DEBOUNCE_CYCLES synchronized samples all
// disagree with it, and schedules repeat pulses from the acceptance time.
// Works with or without BTN_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int         NB   = 4;
  localparam int         DC   = 8;
  localparam int         RD   = 20;
  localparam int         RP   = 5;
  localparam logic [3:0] MASK = 4'b0011;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic          CLK     = 1'b0;
  logic          RESET_N = 1'b0;
  logic [NB-1:0] BTN_RAW = '0;
  logic [NB-1:0] BTN_LEVEL;
  logic [NB-1:0] BTN_PRESSED;
  logic [NB-1:0] BTN_RELEASED;

  button_conditioner #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .BTN_RAW     (BTN_RAW),
    .BTN_LEVEL   (BTN_LEVEL),
    .BTN_PRESSED (BTN_PRESSED),
    .BTN_RELEASED(BTN_RELEASED)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cycle, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // hist holds raw samples taken at each edge; the value the debouncer sees at
  // an edge is the raw input from two edges earlier.
  // ---------------------------------------------------------------------------
  logic [NB-1:0] hist [$];
  logic [NB-1:0] m_level, m_pressed, m_released;
  int            held_at [NB];

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < DC + 2; k++) hist.push_back('0);
    m_level    = '0;
    m_pressed  = '0;
    m_released = '0;
    for (int i = 0; i < NB; i++) held_at[i] = -1;
  endtask

  task automatic model_step(input logic [NB-1:0] raw);
    m_pressed  = '0;
    m_released = '0;
    for (int i = 0; i < NB; i++) begin
      bit all_opp;
      all_opp = 1'b1;
      for (int k = 0; k < DC; k++)
        if (hist[hist.size() - 2 - k][i] == m_level[i]) all_opp = 1'b0;
      if (all_opp) begin
        m_level[i] = ~m_level[i];
        if (m_level[i]) begin
          m_pressed[i] = 1'b1;
          held_at[i]   = cycle;
        end else begin
          m_released[i] = 1'b1;
          held_at[i]    = -1;
        end
      end else if (AR_EN && MASK[i] && held_at[i] >= 0) begin
        int d;
        d = cycle - held_at[i];
        if (d == RD || (d > RD && (d - RD) % RP == 0)) m_pressed[i] = 1'b1;
      end
    end
    hist.push_back(raw);
    void'(hist.pop_front());
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic tick(input logic [NB-1:0] raw);
    BTN_RAW = raw;
    @(posedge CLK);
    cycle++;
    model_step(raw);
    @(negedge CLK);
    check("level",    BTN_LEVEL,    m_level);
    check("pressed",  BTN_PRESSED,  m_pressed);
    check("released", BTN_RELEASED, m_released);
    check("excl",     BTN_PRESSED & BTN_RELEASED, '0);
  endtask

  // Called at a negedge; asserts reset off-edge and returns at a negedge
  // with reset released.
  task automatic apply_reset(input logic [NB-1:0] raw);
    #2;
    RESET_N = 1'b0;
    BTN_RAW = raw;
    #1;
    check("rst_async", {BTN_LEVEL, BTN_PRESSED, BTN_RELEASED}, '0);
    @(negedge CLK);
    check("rst_hold", {BTN_LEVEL, BTN_PRESSED, BTN_RELEASED}, '0);
    RESET_N = 1'b1;
    model_reset();
  endtask

  logic [NB-1:0] acc;
  int            cnt_p, cnt_r;
  logic [NB-1:0] rnd_raw;
  int            run_left [NB];

  initial begin
    model_reset();
    @(negedge CLK);

    // 1. Reset with all buttons held, then release.
    apply_reset(4'hF);
    for (int i = 0; i < 14; i++) begin
      tick(4'hF);
      if (i == 0) check("t1_first", {BTN_LEVEL, BTN_PRESSED, BTN_RELEASED}, '0);
      if (i == 8) check("t1_pre", BTN_LEVEL, 4'h0);
      if (i == 9) check("t1_acc", {BTN_LEVEL, BTN_PRESSED}, 8'hFF);
      if (i == 10) check("t1_once", BTN_PRESSED, 4'h0);
    end
    for (int i = 0; i < 12; i++) begin
      tick(4'h0);
      if (i == 9) check("t1_rel", BTN_RELEASED, 4'hF);
    end

    // 2. Clean press/release on bit 2.
    for (int i = 0; i < 14; i++) begin
      tick(4'b0100);
      if (i == 8) check("t2_pre", BTN_PRESSED, 4'h0);
      if (i == 9) check("t2_acc", {BTN_LEVEL, BTN_PRESSED}, 8'h44);
      if (i == 10) check("t2_once", BTN_PRESSED, 4'h0);
    end
    for (int i = 0; i < 12; i++) begin
      tick(4'h0);
      if (i == 8) check("t2_rel_pre", BTN_RELEASED, 4'h0);
      if (i == 9) check("t2_rel", {BTN_LEVEL, BTN_RELEASED}, 8'h04);
    end

    // 3. Bounce rejection on bit 0: highs of 3, 5, 7 cycles, then hold.
    acc = '0;
    for (int w = 3; w <= 7; w += 2) begin
      for (int i = 0; i < w; i++) begin tick(4'b0001); acc |= BTN_PRESSED | BTN_LEVEL; end
      for (int i = 0; i < 2; i++) begin tick(4'b0000); acc |= BTN_PRESSED | BTN_LEVEL; end
    end
    check("t3_no_glitch", acc, 4'h0);
    for (int i = 0; i < 14; i++) begin
      tick(4'b0001);
      if (i == 9) check("t3_acc", BTN_PRESSED[0], 1'b1);
    end
    for (int i = 0; i < 12; i++) tick(4'h0);

    // 4. Independence: bits 0 and 3 rise together, bit 3 drops after 4 cycles.
    acc = '0;
    for (int i = 0; i < 4; i++) begin tick(4'b1001); acc |= BTN_LEVEL | BTN_PRESSED | BTN_RELEASED; end
    for (int i = 0; i < 12; i++) begin tick(4'b0001); acc |= BTN_LEVEL | BTN_PRESSED | BTN_RELEASED; end
    check("t4_bit3_quiet", acc[3], 1'b0);
    check("t4_bit0_level", BTN_LEVEL, 4'b0001);
    for (int i = 0; i < 12; i++) tick(4'h0);

    // 5. Auto-repeat on bit 1 (masked) and bit 2 (unmasked).
    cnt_p = 0;
    for (int i = 0; i < 70; i++) begin tick(4'b0010); cnt_p += int'(BTN_PRESSED[1]); end
    check("t5_b1_presses", cnt_p, AR_EN ? 10 : 1);
    cnt_p = 0; cnt_r = 0;
    for (int i = 0; i < 14; i++) begin
      tick(4'b0000);
      cnt_p += int'(BTN_PRESSED[1]);
      cnt_r += int'(BTN_RELEASED[1]);
    end
    check("t5_b1_rel_presses", cnt_p, AR_EN ? 1 : 0);
    check("t5_b1_releases", cnt_r, 1);
    cnt_p = 0;
    for (int i = 0; i < 70; i++) begin tick(4'b0100); cnt_p += int'(BTN_PRESSED[2]); end
    for (int i = 0; i < 14; i++) begin tick(4'b0000); cnt_p += int'(BTN_PRESSED[2]); end
    check("t5_b2_presses", cnt_p, 1);

    // 6. Reset while bit 1 is repeating; raw stays high across reset.
    for (int i = 0; i < 40; i++) tick(4'b0010);
    apply_reset(4'b0010);
    cnt_p = 0;
    for (int i = 0; i < 40; i++) begin
      tick(4'b0010);
      cnt_p += int'(BTN_PRESSED[1]);
      if (i == 9) check("t6_acc", BTN_PRESSED, 4'b0010);
    end
    check("t6_presses", cnt_p, AR_EN ? 4 : 1);
    for (int i = 0; i < 14; i++) tick(4'h0);

    // 7. Randomized bouncy stimulus with occasional resets.
    rnd_raw = '0;
    for (int i = 0; i < NB; i++) run_left[i] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NB; i++) begin
        run_left[i]--;
        if (run_left[i] <= 0) begin
          rnd_raw[i]  = ~rnd_raw[i];
          run_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 40))
                                                    : int'($urandom_range(1, 10));
        end
      end
      if ($urandom_range(0, 499) == 0) apply_reset(rnd_raw);
      tick(rnd_raw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of the game controller. Takes raw, asynchronous, bouncy push-button lines from the board and produces synchronized, debounced levels plus one-cycle press and release pulses, all in the 40 MHz domain. The top level feeds the debounced levels (left, right, A, B) into the controller's button inputs in place of the raw pins.

Parameters:
NUM_BUTTONS, 4, number of independent button channels (bit 0 left, 1 right, 2 A, 3 B)
DEBOUNCE_CYCLES, 400000, consecutive stable cycles required before accepting a new level (10 ms at 40 MHz); legal range >= 1
REPEAT_DELAY, 12000000, cycles from the initial press pulse to the first auto-repeat pulse (300 ms); only used with the optional feature
REPEAT_PERIOD, 4000000, cycles between successive auto-repeat pulses (100 ms); only used with the optional feature
REPEAT_MASK, 4'b0011, per-channel auto-repeat enable; width NUM_BUTTONS

Ports:
CLK  input  1  system clock, 40 MHz
RESET_N  input  1  asynchronous active-low reset
BTN_RAW  input  NUM_BUTTONS  raw button pins, asynchronous, active-high
BTN_LEVEL  output  NUM_BUTTONS  debounced level, registered
BTN_PRESSED  output  NUM_BUTTONS  one-cycle pulse on an accepted 0->1 transition, and on each auto-repeat
BTN_RELEASED  output  NUM_BUTTONS  one-cycle pulse on an accepted 1->0 transition

Behaviour:
- One clock (CLK). RESET_N is asynchronous and active-low. All state, including synchronizer flops, clears immediately on assertion.
- Reset values: BTN_LEVEL=0, BTN_PRESSED=0, BTN_RELEASED=0, debounce and repeat counters=0.
- Release from reset is sampled on CLK like any other input. No output may pulse in the first cycle after deassertion, even if BTN_RAW is high. A held button is accepted through normal debounce.
- Synchronizer: 2-flop chain per channel (s1, s2), reset to 0.
- Debounce, per channel: counter of width $clog2(DEBOUNCE_CYCLES)+1.
  - If s2 == BTN_LEVEL, the counter clears.
  - Otherwise the counter increments.
  - When s2 != BTN_LEVEL and counter == DEBOUNCE_CYCLES-1, BTN_LEVEL <= s2 and the counter clears.
- Latency: raw change held steady before edge 1 gives BTN_LEVEL updated at edge DEBOUNCE_CYCLES+2.
- Glitch rejection: any s2 excursion shorter than DEBOUNCE_CYCLES cycles produces no output change, and the counter restarts from 0.
- Pulses are registered and asserted in the same cycle BTN_LEVEL changes. Each is high for exactly one cycle.
- PRESSED and RELEASED are never both high on the same channel in the same cycle.
- Channels are fully independent. Simultaneous transitions on several channels yield simultaneous pulses.
- Counter saturation: counters must never wrap. Parameter values are bounded so the width holds the terminal count.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined: each channel with REPEAT_MASK[i]=1 runs a state machine IDLE -> DELAY -> REPEAT, with its own repeat counter.
  - IDLE: on accepted press, go to DELAY and clear the counter.
  - DELAY: when the counter reaches REPEAT_DELAY-1, pulse BTN_PRESSED, clear the counter and go to REPEAT.
  - REPEAT: every REPEAT_PERIOD cycles, pulse BTN_PRESSED.
  - Accepted release from any state returns to IDLE in the same cycle as the BTN_RELEASED pulse. No repeat pulse occurs in that cycle.
  - Reset forces IDLE.
- Not defined: no repeat logic is synthesized. BTN_PRESSED pulses once per accepted press only. REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK are ignored.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, NUM_BUTTONS=4, REPEAT_MASK=4'b0011.
1. Reset and idle: BTN_RAW=4'b1111 during reset, then release -> all outputs 0 at reset and in the first cycle after release; BTN_LEVEL=4'b1111 at edge 10, with a single PRESSED=4'b1111 pulse.
2. Clean press/release on bit 2: raw high at edge 1 -> LEVEL[2]=1 and PRESSED[2]=1 for one cycle at edge 10; raw low later -> RELEASED[2] pulse exactly 10 edges after the drop.
3. Bounce rejection: toggle raw bit 0 with high widths of 3, 5 and 7 cycles, then hold high -> no pulse during the toggling; a single PRESSED[0] pulse 8 cycles after the final s2 rise.
4. Independence: raw bits 0 and 3 rise in the same cycle, bit 3 drops after 4 cycles -> only bit 0 pulses; bit 3 outputs stay 0.
5. Auto-repeat on (BTN_AUTOREPEAT_EN defined), bit 1 held 60 cycles past acceptance -> PRESSED[1] at acceptance, +20, then every +5 (+25, +30, ...); release -> RELEASED[1] pulse and no further PRESSED. Repeat the same stimulus on bit 2 -> exactly one PRESSED[2].
6. Mid-operation reset: assert RESET_N=0 while bit 1 is in REPEAT -> outputs 0 immediately, asynchronously; after release with raw still high -> fresh debounce of 10 edges and a single press pulse, with the repeat sequence restarting from DELAY.
